// File: rtl/prbs_checker.sv
// PRBS receiver/checker: self-synchronises a local LFSR to the incoming stream,
// then free-runs it and accumulates saturating bit/word error statistics.

package lfsr_pkg;
  localparam logic [7:1] PRBS7 = 7'b1100000;
endpackage

module prbs_checker #(
  parameter int                     POLY_DEGREE   = 7,
  parameter logic [POLY_DEGREE:1]   POLYNOMIAL    = lfsr_pkg::PRBS7,
  parameter int                     DATA_WIDTH    = 8,
  parameter int                     LOCK_COUNT    = 16,
  parameter int                     UNLOCK_COUNT  = 4,
  parameter int                     ERR_CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     clear_cnt,
  output logic                     locked,
  output logic                     err_valid,
  output logic [DATA_WIDTH-1:0]    err_bits,
  output logic [ERR_CNT_WIDTH-1:0] err_word_cnt,
  output logic [ERR_CNT_WIDTH-1:0] err_bit_cnt
);

  // state     | meaning
  // ST_SEARCH | received bits feed the LFSR; counting clean beats toward lock
  // ST_LOCKED | LFSR free-runs on its own prediction; errors are counted
  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int LC_W  = $clog2(LOCK_COUNT + 1);
  localparam int UC_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W = ((ERR_CNT_WIDTH > PC_W) ? ERR_CNT_WIDTH : PC_W) + 1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [0:0]               fsm_q, fsm_d;
  logic [POLY_DEGREE-1:0]   state_q, state_d;
  logic [LC_W-1:0]          run_q, run_d;
  logic [UC_W-1:0]          bad_q, bad_d;
  logic                     err_valid_q, err_valid_d;
  logic [DATA_WIDTH-1:0]    err_bits_q, err_bits_d;
  logic [ERR_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;

  logic [POLY_DEGREE-1:0]   poly_rev;
  logic [POLY_DEGREE-1:0]   lfsr;
  logic [DATA_WIDTH-1:0]    mismatch;
  logic                     pred;
  logic [PC_W-1:0]          pc;
  logic [SUM_W-1:0]         bit_sum;

  // state_q[0] is the oldest bit (tap position POLY_DEGREE), so the tap
  // vector is applied bit-reversed against it.
  always_comb begin
    for (int j = 0; j < POLY_DEGREE; j++) begin
      poly_rev[j] = POLYNOMIAL[POLY_DEGREE - j];
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    run_d       = run_q;
    bad_d       = bad_q;
    err_valid_d = 1'b0;
    err_bits_d  = err_bits_q;
    word_cnt_d  = word_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    mismatch    = '0;
    lfsr        = state_q;
    pred        = 1'b0;
    bit_sum     = '0;

    for (int i = 0; i < DATA_WIDTH; i++) begin
      pred        = ^(lfsr & poly_rev);
      mismatch[i] = pred ^ in_data[i];
      lfsr        = {(fsm_q == ST_LOCKED) ? pred : in_data[i], lfsr[POLY_DEGREE-1:1]};
    end
    pc = PC_W'($countones(mismatch));

    if (in_valid) begin
      state_d = lfsr;
      if (fsm_q == ST_SEARCH) begin
        if ((mismatch == '0) && (lfsr != '0)) run_d = run_q + 1'b1;
        else                                  run_d = '0;
        if (run_d == LC_W'(LOCK_COUNT)) begin
          fsm_d = ST_LOCKED;
          run_d = '0;
        end
      end else begin
        err_valid_d = 1'b1;
        err_bits_d  = mismatch;
        if (mismatch != '0) begin
          if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
          bit_sum   = SUM_W'(bit_cnt_q) + SUM_W'(pc);
          bit_cnt_d = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : bit_sum[ERR_CNT_WIDTH-1:0];
          bad_d     = bad_q + 1'b1;
        end else begin
          bad_d = '0;
        end
        if (bad_d == UC_W'(UNLOCK_COUNT)) begin
          fsm_d = ST_SEARCH;
          bad_d = '0;
          run_d = '0;
        end
      end
    end

    // Clear wins over the contribution of a coincident errored beat.
    if (clear_cnt) begin
      word_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= ST_SEARCH;
      state_q     <= '0;
      run_q       <= '0;
      bad_q       <= '0;
      err_valid_q <= 1'b0;
      err_bits_q  <= '0;
      word_cnt_q  <= '0;
      bit_cnt_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      err_valid_q <= err_valid_d;
      err_bits_q  <= err_bits_d;
      word_cnt_q  <= word_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign locked       = (fsm_q == ST_LOCKED);
  assign err_valid    = err_valid_q;
  assign err_bits     = err_bits_q;
  assign err_word_cnt = word_cnt_q;
  assign err_bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: a behavioural PRBS7 source and a
// bit-history reference model drive two instances (32-bit and 4-bit counters).

module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       clear_cnt;

  logic        locked, err_valid;
  logic [7:0]  err_bits;
  logic [31:0] err_word_cnt, err_bit_cnt;
  logic        locked4, err_valid4;
  logic [7:0]  err_bits4;
  logic [3:0]  err_word_cnt4, err_bit_cnt4;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear_cnt(clear_cnt), .locked(locked), .err_valid(err_valid),
    .err_bits(err_bits), .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt)
  );

  prbs_checker #(.ERR_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .clear_cnt(clear_cnt), .locked(locked4), .err_valid(err_valid4),
    .err_bits(err_bits4), .err_word_cnt(err_word_cnt4), .err_bit_cnt(err_bit_cnt4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // PRBS7 source: x[n] = x[n-6] ^ x[n-7], seeded with all ones.
  bit gen_hist [7];

  function automatic logic [7:0] gen_word();
    logic [7:0] w;
    bit nb;
    for (int i = 0; i < 8; i++) begin
      nb = gen_hist[5] ^ gen_hist[6];
      for (int a = 6; a > 0; a--) gen_hist[a] = gen_hist[a-1];
      gen_hist[0] = nb;
      w[i] = nb;
    end
    return w;
  endfunction

  // Reference model: hist[a] is the bit inserted a+1 bit-times ago.
  bit         m_hist [7];
  bit         m_locked;
  int         m_run, m_bad;
  longint     m_words, m_bits;
  bit         m_ev;
  logic [7:0] m_eb;

  function automatic longint sat(input longint t, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (t > mx) ? mx : t;
  endfunction

  task automatic model_reset();
    foreach (m_hist[a]) m_hist[a] = 1'b0;
    m_locked = 0; m_run = 0; m_bad = 0;
    m_words = 0; m_bits = 0; m_ev = 0; m_eb = '0;
  endtask

  task automatic model_beat(input bit v, input logic [7:0] d, input bit clr);
    logic [7:0] mm;
    bit p, nb, nz;
    m_ev = 0;
    if (v) begin
      mm = '0;
      for (int i = 0; i < 8; i++) begin
        p     = m_hist[5] ^ m_hist[6];
        mm[i] = p ^ d[i];
        nb    = m_locked ? p : d[i];
        for (int a = 6; a > 0; a--) m_hist[a] = m_hist[a-1];
        m_hist[0] = nb;
      end
      nz = 0;
      foreach (m_hist[a]) nz |= m_hist[a];
      if (!m_locked) begin
        m_run = (mm == 0 && nz) ? m_run + 1 : 0;
        if (m_run == 16) begin m_locked = 1; m_run = 0; end
      end else begin
        m_ev = 1;
        m_eb = mm;
        if (mm != 0) begin
          m_words += 1;
          m_bits  += $countones(mm);
          m_bad   += 1;
        end else begin
          m_bad = 0;
        end
        if (m_bad == 4) begin m_locked = 0; m_bad = 0; m_run = 0; end
      end
    end
    if (clr) begin m_words = 0; m_bits = 0; end
  endtask

  task automatic check_outputs();
    check_val("locked", longint'(locked), longint'(m_locked));
    check_val("err_valid", longint'(err_valid), longint'(m_ev));
    if (m_ev) check_val("err_bits", longint'(err_bits), longint'(m_eb));
    check_val("word_cnt", longint'(err_word_cnt), sat(m_words, 32));
    check_val("bit_cnt", longint'(err_bit_cnt), sat(m_bits, 32));
    check_val("locked4", longint'(locked4), longint'(m_locked));
    check_val("err_valid4", longint'(err_valid4), longint'(m_ev));
    if (m_ev) check_val("err_bits4", longint'(err_bits4), longint'(m_eb));
    check_val("word_cnt4", longint'(err_word_cnt4), sat(m_words, 4));
    check_val("bit_cnt4", longint'(err_bit_cnt4), sat(m_bits, 4));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    rst = 1'b0; in_valid = v; in_data = d; clear_cnt = clr;
    @(posedge clk);
    model_beat(v, d, clr);
    #1;
    check_outputs();
  endtask

  // Valid beats take the next PRBS word XOR flip; idle beats carry junk.
  task automatic send(input bit v, input logic [7:0] flip, input bit clr);
    logic [7:0] d;
    if (v) d = gen_word() ^ flip;
    else   d = 8'($urandom);
    step(v, d, clr);
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst = 1'b1; in_valid = 1'($urandom); in_data = 8'($urandom); clear_cnt = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_outputs();
    end
  endtask

  function automatic logic [7:0] three_bit_mask();
    logic [7:0] m;
    m = '0;
    while ($countones(m) < 3) m[$urandom_range(0, 7)] = 1'b1;
    return m;
  endfunction

  // Feeds clean beats (optionally with idle gaps) until lock; returns the
  // number of valid beats consumed, or -1 if the cycle budget runs out.
  task automatic lock_up(input bit gaps, output int beats);
    bit v;
    beats = 0;
    for (int c = 0; c < 400; c++) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      send(v, 8'h00, 1'b0);
      if (v) beats++;
      if (locked) return;
    end
    beats = -1;
  endtask

  int beats;
  int first_lock;
  logic [7:0] mask;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear_cnt = 1'b0;
    foreach (gen_hist[a]) gen_hist[a] = 1'b1;
    model_reset();

    // 1: reset, then continuous clean PRBS7
    do_reset(2);
    check_val("rst_locked", longint'(locked), 0);
    check_val("rst_word_cnt", longint'(err_word_cnt), 0);
    first_lock = 0;
    for (int b = 1; b <= 1000; b++) begin
      send(1'b1, 8'h00, 1'b0);
      if (b <= 15) check_val("early_locked", longint'(locked), 0);
      if (locked && first_lock == 0) first_lock = b;
    end
    check_val("lock_beat_16_or_17", longint'(first_lock == 16 || first_lock == 17), 1);
    check_val("clean_word_cnt", longint'(err_word_cnt), 0);
    check_val("clean_bit_cnt", longint'(err_bit_cnt), 0);

    // 2: single bit flip on bit 3
    send(1'b1, 8'h08, 1'b0);
    check_val("flip_err_valid", longint'(err_valid), 1);
    check_val("flip_err_bits", longint'(err_bits), 8'h08);
    for (int b = 0; b < 20; b++) send(1'b1, 8'h00, 1'b0);
    check_val("flip_word_cnt", longint'(err_word_cnt), 1);
    check_val("flip_bit_cnt", longint'(err_bit_cnt), 1);
    check_val("flip_locked", longint'(locked), 1);

    // 3: four inverted beats force unlock, then relock on clean data
    send(1'b0, 8'h00, 1'b1);
    for (int b = 0; b < 4; b++) begin
      check_val("inv_still_locked", longint'(locked), 1);
      send(1'b1, 8'hFF, 1'b0);
    end
    check_val("inv_unlocked", longint'(locked), 0);
    check_val("inv_word_cnt", longint'(err_word_cnt), 4);
    check_val("inv_bit_cnt", longint'(err_bit_cnt), 32);
    lock_up(1'b0, beats);
    check_val("relock_beats", longint'(beats), 16);
    check_val("relock_word_cnt", longint'(err_word_cnt), 4);
    check_val("relock_bit_cnt", longint'(err_bit_cnt), 32);

    // 4: all-zero stream never locks
    do_reset(1);
    for (int b = 0; b < 100; b++) step(1'b1, 8'h00, 1'b0);
    check_val("zero_locked", longint'(locked), 0);
    check_val("zero_word_cnt", longint'(err_word_cnt), 0);

    // 5: saturation with 3-bit errors on alternate beats, random idle gaps
    do_reset(1);
    lock_up(1'b1, beats);
    check_val("sat_lock_beats_ok", longint'(beats == 16 || beats == 17), 1);
    for (int e = 0; e < 20; e++) begin
      while ($urandom_range(0, 2) == 0) send(1'b0, 8'h00, 1'b0);
      send(1'b1, three_bit_mask(), 1'b0);
      send(1'b1, 8'h00, 1'b0);
    end
    check_val("sat_word_cnt4", longint'(err_word_cnt4), 4'hF);
    check_val("sat_bit_cnt4", longint'(err_bit_cnt4), 4'hF);
    check_val("sat_word_cnt", longint'(err_word_cnt), 20);
    check_val("sat_bit_cnt", longint'(err_bit_cnt), 60);
    check_val("sat_locked", longint'(locked4), 1);
    mask = three_bit_mask();
    send(1'b1, mask, 1'b1);
    check_val("clr_word_cnt4", longint'(err_word_cnt4), 0);
    check_val("clr_bit_cnt4", longint'(err_bit_cnt4), 0);
    check_val("clr_err_valid", longint'(err_valid4), 1);
    check_val("clr_err_bits", longint'(err_bits4), longint'(mask));

    // 6: reset while locked with counts, idle gaps around it
    send(1'b1, 8'h00, 1'b0);
    send(1'b1, 8'h21, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    do_reset(1);
    check_val("rst6_locked", longint'(locked), 0);
    check_val("rst6_err_valid", longint'(err_valid), 0);
    check_val("rst6_err_bits", longint'(err_bits), 0);
    check_val("rst6_word_cnt", longint'(err_word_cnt), 0);
    check_val("rst6_bit_cnt", longint'(err_bit_cnt), 0);
    lock_up(1'b1, beats);
    check_val("rst6_lock_beats_ok", longint'(beats == 16 || beats == 17), 1);
    for (int b = 0; b < 50; b++) send(($urandom_range(0, 3) != 0), 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
Sequential PRBS receiver/checker. It pairs with the Fibonacci LFSR generator in encoding_lfsr.
- Accepts a parallel PRBS stream of DATA_WIDTH bits per valid beat.
- Self-synchronises its local LFSR to the incoming sequence and declares lock.
- Once locked, free-runs the local LFSR and counts bit and word errors.
- Sits at the sink end of link/BIST paths, reporting lock status and error statistics to a register block.

Parameters:
POLY_DEGREE, 7, LFSR degree; must match the generator.
POLYNOMIAL, lfsr_pkg::PRBS7, tap vector [POLY_DEGREE:1]; same encoding as the generator.
DATA_WIDTH, 8, bits checked per beat; must be ≥1.
LOCK_COUNT, 16, consecutive error-free beats in SEARCH required to declare lock; must be ≥1.
UNLOCK_COUNT, 4, consecutive errored beats in LOCKED that force return to SEARCH; must be ≥1.
ERR_CNT_WIDTH, 32, width of the saturating error counters.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_data carries a beat; no backpressure.
in_data  in  DATA_WIDTH  received bits; bit 0 is earliest in time, matching generator ordering.
clear_cnt  in  1  synchronous clear of both error counters.
locked  out  1  high while FSM is in LOCKED.
err_valid  out  1  pulses with err_bits for each beat checked in LOCKED.
err_bits  out  DATA_WIDTH  per-bit mismatch mask of that beat.
err_word_cnt  out  ERR_CNT_WIDTH  saturating count of errored beats in LOCKED.
err_bit_cnt  out  ERR_CNT_WIDTH  saturating count of mismatched bits in LOCKED.

Behaviour:
- Reset: FSM=SEARCH; LFSR state=0; run counters=0; locked=0; err_valid=0; err_bits=0; both counters=0. Reset mid-operation discards lock and counts immediately on the next edge.
- Nothing updates on beats with in_valid=0. State, FSM and run counters hold.
- Bit serialisation per beat, i=0..DATA_WIDTH-1:
  - predicted bit p = XOR of (state AND reversed POLYNOMIAL);
  - mismatch[i] = p XOR in_data[i];
  - state shifts right, inserting a new bit at position 1.
- SEARCH (feed-forward, self-synchronising):
  - The inserted bit is in_data[i].
  - A beat is clean if mismatch==0 and the post-beat state is non-zero. An all-zero stream never locks.
  - Clean beat: run counter +1. Otherwise the run counter is reset to 0.
  - When the run counter reaches LOCK_COUNT: go to LOCKED, clear the run counter. locked goes high on the same edge that registers the LOCK_COUNT-th clean beat.
  - No counting and no err_valid in SEARCH.
- LOCKED (generator mode):
  - The inserted bit is p, so the local LFSR free-runs and a single channel bit flip yields exactly one mismatch.
  - err_valid and err_bits are registered one cycle after the beat.
  - Errored beat (mismatch≠0): err_word_cnt +1; err_bit_cnt + popcount(mismatch); bad-run counter +1. Clean beat: bad-run counter is reset to 0.
  - When the bad-run counter reaches UNLOCK_COUNT: go to SEARCH, clear run counters. locked drops on the edge registering that beat. That beat still counts and still produces err_valid.
- Counters saturate at all-ones; no wrap. err_bit_cnt addition saturates when the sum would overflow.
- clear_cnt has priority over a simultaneous errored beat: both counters become 0 and that beat's contribution is discarded. err_valid/err_bits for that beat are still produced.
- err_valid is 0 except in the cycle following a checked LOCKED beat.
- Latency: one cycle from in_valid beat to all registered outputs.

Test Plan:
1. Clean PRBS7 stream, generator seeded 7'h7F, in_valid continuous, defaults.
   -> locked=0 through beat 15.
   -> locked=1 after beat 16, or after beat 17 if beat 1 mismatched against the zero state.
   -> err_word_cnt=err_bit_cnt=0 for 1000 beats.
2. After lock, flip in_data[3] on one beat.
   -> err_valid pulses once with err_bits=8'h08.
   -> err_word_cnt=1, err_bit_cnt=1, locked stays 1, no further errors.
3. After lock, invert 4 consecutive beats.
   -> err_word_cnt=4, err_bit_cnt=32, locked falls after the 4th beat.
   -> Clean stream resumes: relock after 16 clean beats, counters hold at 4/32.
4. in_data=0 with in_valid=1 for 100 beats after reset.
   -> locked never asserts; counters stay 0.
5. ERR_CNT_WIDTH=4: after lock, alternate errored beats (3 bits flipped) and clean beats, 20 errored beats total.
   -> err_word_cnt=4'hF, err_bit_cnt=4'hF, locked stays 1.
   -> clear_cnt asserted coincident with an errored beat -> both counters read 0 the next cycle.
6. Assert rst for one cycle while locked with non-zero counts, in_valid gaps interleaved.
   -> All outputs 0 the next cycle; relock follows scenario 1 timing, counting only valid beats.
